// File: rtl/alu_seq_ctrl.sv
// Button-driven sequential ALU: tick-sampled debounced commands feed an IDLE/CALC/HOLD controller.
// Optional macro ALU_CHAIN_EN: the CALC result is also written back into reg_a so executes chain.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       pb,
  input  logic [WIDTH-1:0] sw,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] led,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [3:0]       sync1, sync2, smp, fire;
  logic             armed;
  logic             do_clr, do_exec, do_lda, do_ldb;
  logic [WIDTH-1:0] reg_a, reg_b, result;
  logic             ovf_q;
  logic [WIDTH:0]   alu_full;

  // Free-running sample-period counter; only reset touches it
  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // The first tick after reset only primes smp, so buttons held through reset never fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      smp   <= '0;
      armed <= 1'b0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
      if (tick) begin
        smp   <= sync2;
        armed <= 1'b1;
      end
    end
  end

  assign fire    = (tick && armed) ? (sync2 & ~smp) : 4'b0000;
  assign do_clr  = fire[0];
  assign do_exec = fire[3] & ~fire[0];
  assign do_lda  = fire[1] & ~fire[0] & ~fire[3];
  assign do_ldb  = fire[2] & ~fire[0] & ~fire[3] & ~fire[1];

  // ALU: bit WIDTH carries carry/borrow/shifted-out bit
  always_comb begin
    alu_full = '0;
    case (op)
      3'b000:  alu_full = {1'b0, reg_a} + {1'b0, reg_b};
      3'b001:  alu_full = {1'b0, reg_a} - {1'b0, reg_b};
      3'b010:  alu_full = {1'b0, reg_a & reg_b};
      3'b011:  alu_full = {1'b0, reg_a | reg_b};
      3'b100:  alu_full = {1'b0, reg_a ^ reg_b};
      3'b101:  alu_full = {1'b0, ~reg_a};
      3'b110:  alu_full = {reg_a, 1'b0};
      3'b111:  alu_full = {reg_a[0], 1'b0, reg_a[WIDTH-1:1]};
      default: alu_full = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a  <= '0;
      reg_b  <= '0;
      result <= '0;
      ovf_q  <= 1'b0;
    end else if (do_clr) begin
      reg_a  <= '0;
      reg_b  <= '0;
      result <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_lda) reg_a <= sw;
      if (do_ldb) reg_b <= sw;
      if (state_q == CALC) begin
        result <= alu_full[WIDTH-1:0];
        ovf_q  <= alu_full[WIDTH];
`ifdef ALU_CHAIN_EN
        reg_a  <= alu_full[WIDTH-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (do_clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (do_exec) state_d = CALC;
        CALC:    state_d = HOLD;
        HOLD: begin
          if (do_exec)               state_d = CALC;
          else if (do_lda || do_ldb) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode directly from flops: state, reg_a, result, ovf_q
  always_comb begin
    busy  = 1'b0;
    valid = 1'b0;
    ovf   = 1'b0;
    led   = reg_a;
    case (state_q)
      CALC: busy = 1'b1;
      HOLD: begin
        valid = 1'b1;
        ovf   = ovf_q;
        led   = result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (WIDTH=4, TICK_DIV=4): vector table, corner sequences, random vs model.
module tb_alu_seq_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned TD = 4;
  localparam int          M  = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   pb;
  logic [W-1:0] sw;
  logic [2:0]   op;
  logic [W-1:0] led;
  logic         ovf, busy, valid;

  alu_seq_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .pb(pb), .sw(sw), .op(op),
    .led(led), .ovf(ovf), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_total = 0;
  int busy_snap;

  always @(negedge clk) if (busy === 1'b1) busy_total++;

  // Reference model state (transaction level)
  int m_a, m_b, m_res, m_ovf, m_hold, m_busy_exp;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] led;
    logic       ovf;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ref_alu(input int a, input int b, input int o, output int r, output int f);
    f = 0;
    case (o)
      0: begin r = (a + b) % M; f = (a + b >= M) ? 1 : 0; end
      1: begin r = (a - b + M) % M; f = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (M - 1) - a;
      6: begin r = (a * 2) % M; f = (a >= M / 2) ? 1 : 0; end
      default: begin r = a / 2; f = a % 2; end
    endcase
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_ovf = 0; m_hold = 0;
  endtask

  task automatic model_cmd(input logic [3:0] mask, input int s, input int o);
    m_busy_exp = 0;
    if (mask[0]) begin
      model_reset();
    end else if (mask[3]) begin
      ref_alu(m_a, m_b, o, m_res, m_ovf);
`ifdef ALU_CHAIN_EN
      m_a = m_res;
`endif
      m_hold = 1;
      m_busy_exp = 1;
    end else if (mask[1]) begin
      m_a = s; m_hold = 0;
    end else if (mask[2]) begin
      m_b = s; m_hold = 0;
    end
  endtask

  // Hold buttons long enough for sync plus at least two ticks, then release likewise
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    busy_snap = busy_total;
    pb = mask;
    repeat (3 * TD) @(negedge clk);
    pb = 4'b0000;
    repeat (3 * TD) @(negedge clk);
  endtask

  task automatic cmd(input logic [3:0] mask, input int s, input int o);
    sw = W'(s);
    op = 3'(o);
    press(mask);
    model_cmd(mask, s, o);
  endtask

  task automatic check_model(input string name);
    check({name, ".led"},   int'(led),   m_hold ? m_res : m_a);
    check({name, ".ovf"},   int'(ovf),   m_hold ? m_ovf : 0);
    check({name, ".valid"}, int'(valid), m_hold);
    check({name, ".busy"},  busy_total - busy_snap, m_busy_exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int cb, cv, exp2, expa;
  logic [3:0] rmask;

  initial begin
    tbl[0]  = '{4'b0111, 4'b0011, 3'd0, 4'b1010, 1'b0};
    tbl[1]  = '{4'b1100, 4'b0101, 3'd0, 4'b0001, 1'b1};
    tbl[2]  = '{4'b0011, 4'b0101, 3'd1, 4'b1110, 1'b1};
    tbl[3]  = '{4'b1001, 4'b0011, 3'd1, 4'b0110, 1'b0};
    tbl[4]  = '{4'b1100, 4'b1010, 3'd2, 4'b1000, 1'b0};
    tbl[5]  = '{4'b1100, 4'b1010, 3'd3, 4'b1110, 1'b0};
    tbl[6]  = '{4'b1100, 4'b1010, 3'd4, 4'b0110, 1'b0};
    tbl[7]  = '{4'b1100, 4'b1010, 3'd5, 4'b0011, 1'b0};
    tbl[8]  = '{4'b1011, 4'b0000, 3'd6, 4'b0110, 1'b1};
    tbl[9]  = '{4'b1011, 4'b0000, 3'd7, 4'b0101, 1'b1};
    tbl[10] = '{4'b0100, 4'b0000, 3'd6, 4'b1000, 1'b0};
    tbl[11] = '{4'b0110, 4'b0000, 3'd7, 4'b0011, 1'b0};
    tbl[12] = '{4'b1111, 4'b0001, 3'd0, 4'b0000, 1'b1};
    tbl[13] = '{4'b0000, 4'b0001, 3'd1, 4'b1111, 1'b1};

    pb = '0; sw = '0; op = '0; rst_n = 1'b0;
    #1;
    check("async_reset.led", int'(led), 0);
    check("async_reset.valid", int'(valid), 0);
    do_reset();
    @(negedge clk);
    check("reset.led", int'(led), 0);
    check("reset.ovf", int'(ovf), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.valid", int'(valid), 0);

    // Vector table: load A (leaves HOLD), load B, execute
    foreach (tbl[i]) begin
      cmd(4'b0010, int'(tbl[i].a), 0);
      check("tbl.load_a_idle", int'(valid), 0);
      check("tbl.load_a_led", int'(led), int'(tbl[i].a));
      cmd(4'b0100, int'(tbl[i].b), 0);
      cmd(4'b1000, 0, int'(tbl[i].op));
      check("tbl.led", int'(led), int'(tbl[i].led));
      check("tbl.ovf", int'(ovf), int'(tbl[i].ovf));
      check("tbl.valid", int'(valid), 1);
      check("tbl.busy_cycles", busy_total - busy_snap, 1);
    end

    // Latency: busy for exactly one clk, valid the clk after
    cmd(4'b0010, 7, 0);
    cmd(4'b0100, 3, 0);
    sw = '0; op = 3'd0;
    @(negedge clk);
    busy_snap = busy_total;
    pb = 4'b1000;
    cb = -1; cv = -1;
    for (int i = 0; i < int'(3 * TD); i++) begin
      @(negedge clk);
      if (busy === 1'b1 && cb < 0) cb = i;
      if (valid === 1'b1 && cv < 0) cv = i;
    end
    pb = 4'b0000;
    repeat (3 * TD) @(negedge clk);
    check("latency.busy_seen", (cb >= 0) ? 1 : 0, 1);
    check("latency.valid_after_busy", cv - cb, 1);
    check("latency.busy_cycles", busy_total - busy_snap, 1);
    check("latency.led", int'(led), 10);
    model_cmd(4'b1000, 0, 0);

    // Held load A fires once; later switch change ignored
    cmd(4'b0001, 0, 0);
    @(negedge clk);
    sw = 4'b1001;
    pb = 4'b0010;
    repeat (10 * TD) @(negedge clk);
    sw = 4'b0110;
    repeat (4 * TD) @(negedge clk);
    pb = 4'b0000;
    repeat (3 * TD) @(negedge clk);
    check("held_load.led", int'(led), 9);
    model_cmd(4'b0010, 9, 0);

    // Clear and execute together in HOLD: clear wins, no CALC
    cmd(4'b0100, 5, 0);
    cmd(4'b1000, 0, 0);
    check("clr_exec.pre_valid", int'(valid), 1);
    cmd(4'b1001, 0, 0);
    check("clr_exec.led", int'(led), 0);
    check("clr_exec.valid", int'(valid), 0);
    check("clr_exec.busy_cycles", busy_total - busy_snap, 0);

    // Chain behaviour
    cmd(4'b0010, 1, 0);
    cmd(4'b0100, 1, 0);
    cmd(4'b1000, 0, 0);
    check("chain.first", int'(led), 2);
    cmd(4'b1000, 0, 0);
`ifdef ALU_CHAIN_EN
    exp2 = 3; expa = 3;
`else
    exp2 = 2; expa = 1;
`endif
    check("chain.second", int'(led), exp2);
    cmd(4'b0100, 1, 0);
    check("chain.reg_a", int'(led), expa);

    // Async reset mid-HOLD, buttons held across release
    cmd(4'b0010, 7, 0);
    cmd(4'b1000, 0, 0);
    check("rst_hold.pre_valid", int'(valid), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_hold.led", int'(led), 0);
    check("rst_hold.valid", int'(valid), 0);
    check("rst_hold.ovf", int'(ovf), 0);
    sw = 4'b1001;
    pb = 4'b1010;
    busy_snap = busy_total;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6 * TD) @(negedge clk);
    pb = 4'b0000;
    repeat (3 * TD) @(negedge clk);
    check("rst_held.led", int'(led), 0);
    check("rst_held.valid", int'(valid), 0);
    check("rst_held.busy_cycles", busy_total - busy_snap, 0);
    pb = 4'b0010;
    busy_snap = busy_total;
    model_cmd(4'b0010, 9, 0);
    repeat (3 * TD) @(negedge clk);
    pb = 4'b0000;
    repeat (3 * TD) @(negedge clk);
    check("post_rst_load.led", int'(led), 9);

    // Random commands against the model
    for (int i = 0; i < 40; i++) begin
      rmask = 4'($urandom_range(0, 15));
      if (rmask[0] && ($urandom_range(0, 3) != 0)) rmask[0] = 1'b0;
      cmd(rmask, int'($urandom_range(0, M - 1)), int'($urandom_range(0, 7)));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
